// File: rtl/pc_if.sv
// pc_if: control/status bundle between the fetch-stage controller and pc_unit.
//   master : drives Halt, Branch, Zero, Jump, JumpReg, Call, Return, AddressJump;
//            observes pc_out, halted, ras_count, ras_error.
//   slave  : the program counter (pc_unit) side of the same signals.
interface pc_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic             Halt;
  logic             Branch;
  logic             Zero;
  logic             Jump;
  logic             JumpReg;
  logic             Call;
  logic             Return;
  logic [WIDTH-1:0] AddressJump;
  logic [WIDTH-1:0] pc_out;
  logic             halted;
  logic [CW-1:0]    ras_count;
  logic             ras_error;

  modport master (
    output Halt, Branch, Zero, Jump, JumpReg, Call, Return, AddressJump,
    input  pc_out, halted, ras_count, ras_error
  );

  modport slave (
    input  Halt, Branch, Zero, Jump, JumpReg, Call, Return, AddressJump,
    output pc_out, halted, ras_count, ras_error
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with step / branch / jump / register jump /
// call / return selection, registered halt acknowledge and optional return-address
// stack (RAS), enabled by defining the macro PC_RAS_EN.
// Ports:
//   Clock   : rising-edge clock
//   Reset   : asynchronous active-high reset
//   bus     : pc_if.slave -- control inputs (Halt, Branch, Zero, Jump, JumpReg,
//             Call, Return, AddressJump) and status outputs (pc_out, halted,
//             ras_count, ras_error); all outputs come straight from registers.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic Clock,
  input  logic Reset,
  pc_if.slave  bus
);

  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_pc_step;

  // Sequential address wraps modulo 2^WIDTH by construction.
  assign w_pc_step = r_pc + WIDTH'(STEP);

`ifdef PC_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]    r_wp;
  logic [CW-1:0]    r_count;
  logic             r_err;
  logic             w_push;
  logic             w_pop;
  logic             w_err_set;
  logic             w_ras_full;
  logic [WIDTH-1:0] w_ras_top;

  assign w_ras_full = (r_count == CW'(RAS_DEPTH));
  // r_wp points at the next free slot; the newest entry sits just below it.
  assign w_ras_top  = r_ras[r_wp - PW'(1)];
`endif

  // Halt state and PC register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_RUN;
      r_pc    <= RESET_VECTOR;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  // Next-state and next-PC selection in priority order.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
`ifdef PC_RAS_EN
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_err_set    = 1'b0;
`endif
    if (bus.Halt) begin
      w_state_next = S_HALTED;
    end else begin
      w_state_next = S_RUN;
`ifdef PC_RAS_EN
      if (bus.Return && (r_count != '0)) begin
        w_pc_next = w_ras_top;
        w_pop     = 1'b1;
      end else
`endif
      if (bus.Branch && bus.Zero) begin
        w_pc_next = bus.AddressJump;
      end else if (bus.Jump) begin
        w_pc_next = bus.AddressJump;
      end else if (bus.JumpReg) begin
        w_pc_next = bus.AddressJump;
      end else if (bus.Call) begin
        w_pc_next = bus.AddressJump;
`ifdef PC_RAS_EN
        w_push    = 1'b1;
        w_err_set = w_ras_full;
`endif
      end else begin
        w_pc_next = w_pc_step;
`ifdef PC_RAS_EN
        // Reaching here with Return set means the stack was empty.
        w_err_set = bus.Return;
`endif
      end
    end
  end

`ifdef PC_RAS_EN
  // Stack pointer, occupancy and sticky error. A push into a full stack
  // overwrites the oldest entry because r_wp wraps onto it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wp    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + PW'(1);
        if (!w_ras_full) begin
          r_count <= r_count + CW'(1);
        end
      end else if (w_pop) begin
        r_wp    <= r_wp - PW'(1);
        r_count <= r_count - CW'(1);
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Entry storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge Clock) begin
    if (w_push && !Reset) begin
      r_ras[r_wp] <= w_pc_step;
    end
  end

  assign bus.ras_count = r_count;
  assign bus.ras_error = r_err;
`else
  assign bus.ras_count = CW'(0);
  assign bus.ras_error = 1'b0;
`endif

  assign bus.pc_out = r_pc;
  assign bus.halted = (r_state == S_HALTED);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed bench for pc_unit. Instance A (WIDTH=32, RESET_VECTOR=0x100)
// is checked against a behavioural model through an expected-result queue;
// instance B (WIDTH=8, RESET_VECTOR=0xFC) covers halt and 8-bit wrap.
module tb_pc_unit;

  localparam int unsigned AW    = 32;
  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 4;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic        halted;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  pc_if #(.WIDTH(AW), .RAS_DEPTH(DEPTH)) ifa ();
  pc_if #(.WIDTH(BW), .RAS_DEPTH(DEPTH)) ifb ();

  pc_unit #(.WIDTH(AW), .STEP(1), .RESET_VECTOR(32'h100), .RAS_DEPTH(DEPTH)) dut_a (
    .Clock (clk),
    .Reset (rst_a),
    .bus   (ifa)
  );

  pc_unit #(.WIDTH(BW), .STEP(1), .RESET_VECTOR(8'hFC), .RAS_DEPTH(DEPTH)) dut_b (
    .Clock (clk),
    .Reset (rst_b),
    .bus   (ifb)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] m_pc;
  logic        m_halted;
  logic        m_err;
  logic [31:0] m_stack[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'h100;
    m_halted = 1'b0;
    m_err    = 1'b0;
    m_stack.delete();
    exp_q.delete();
  endtask

  task automatic check_a_now(input string tag);
    chk({tag, ".pc"},     ifa.pc_out,         m_pc);
    chk({tag, ".halted"}, 32'(ifa.halted),    32'(m_halted));
    chk({tag, ".cnt"},    32'(ifa.ras_count), m_stack.size());
    chk({tag, ".err"},    32'(ifa.ras_error), 32'(m_err));
  endtask

  // Drive one cycle on A, predict its result, then compare after the edge.
  task automatic drive_a(input string tag, input logic h, input logic br, input logic z,
                         input logic j, input logic jr, input logic c, input logic r,
                         input logic [31:0] aj);
    exp_t        e;
    logic [31:0] dropped;
    ifa.Halt = h; ifa.Branch = br; ifa.Zero = z; ifa.Jump = j;
    ifa.JumpReg = jr; ifa.Call = c; ifa.Return = r; ifa.AddressJump = aj;
    if (h) begin
      m_halted = 1'b1;
    end else begin
      m_halted = 1'b0;
      if (RAS_ON && r && (m_stack.size() > 0)) begin
        m_pc = m_stack.pop_back();
      end else if (br && z) begin
        m_pc = aj;
      end else if (j || jr) begin
        m_pc = aj;
      end else if (c) begin
        if (RAS_ON) begin
          m_stack.push_back(m_pc + 32'd1);
          if (m_stack.size() > DEPTH) begin
            dropped = m_stack.pop_front();
            m_err   = 1'b1;
          end
        end
        m_pc = aj;
      end else begin
        if (RAS_ON && r) m_err = 1'b1;
        m_pc = m_pc + 32'd1;
      end
    end
    e.pc = m_pc; e.halted = m_halted; e.cnt = m_stack.size(); e.err = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".pc"},     ifa.pc_out,         e.pc);
    chk({tag, ".halted"}, 32'(ifa.halted),    32'(e.halted));
    chk({tag, ".cnt"},    32'(ifa.ras_count), e.cnt);
    chk({tag, ".err"},    32'(ifa.ras_error), 32'(e.err));
  endtask

  task automatic idle(input string tag);
    drive_a(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    ifa.Halt = 1'b0; ifa.Branch = 1'b0; ifa.Zero = 1'b0; ifa.Jump = 1'b0;
    ifa.JumpReg = 1'b0; ifa.Call = 1'b0; ifa.Return = 1'b0; ifa.AddressJump = '0;
    ifb.Halt = 1'b0; ifb.Branch = 1'b0; ifb.Zero = 1'b0; ifb.Jump = 1'b0;
    ifb.JumpReg = 1'b0; ifb.Call = 1'b0; ifb.Return = 1'b0; ifb.AddressJump = '0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    model_reset();
    #1;
    check_a_now("rst");
    chk("rst_b.pc", 32'(ifb.pc_out), 32'h0FC);
    chk("rst_b.halted", 32'(ifb.halted), 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset vector then sequential stepping; B walks up to 0xFF alongside.
    idle("step1");
    idle("step2");
    idle("step3");
    chk("b_pre.pc", 32'(ifb.pc_out), 32'h0FF);
    chk("b_pre.halted", 32'(ifb.halted), 32'd0);

    // B frozen at 0xFF for three edges, then wraps to 0x00 on release.
    ifb.Halt = 1'b1;
    idle("step4");
    idle("step5");
    idle("step6");
    chk("b_halt.pc", 32'(ifb.pc_out), 32'h0FF);
    chk("b_halt.halted", 32'(ifb.halted), 32'd1);
    ifb.Halt = 1'b0;
    idle("step7");
    chk("b_wrap.pc", 32'(ifb.pc_out), 32'h000);
    chk("b_wrap.halted", 32'(ifb.halted), 32'd0);

    // Priority among branch/jump/call, untaken branch and register jump.
    drive_a("jmp10", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
    drive_a("prio",  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40);
    drive_a("nz",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h99);
    drive_a("jr",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200);

    // Call, two idle edges, return.
    drive_a("jmp20", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20);
    drive_a("call",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80);
    idle("cidle1");
    idle("cidle2");
    drive_a("ret",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Return with nothing on the stack steps.
    drive_a("ret0",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Five nested calls into a four-deep stack, then five returns.
    for (int i = 0; i < 5; i++) begin
      drive_a("ncall", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300 + 32'(i * 16));
    end
    for (int i = 0; i < 5; i++) begin
      drive_a("nret", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    end

    // Halt ignores every control input, then the first free edge advances.
    drive_a("halt1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h777);
    drive_a("halt2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h777);
    idle("unhalt");

    // Asynchronous reset right after a call, between clock edges.
    drive_a("call5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h500);
    ifa.Call = 1'b0;
    ifa.AddressJump = '0;
    #2;
    rst_a = 1'b1;
    #1;
    model_reset();
    check_a_now("arst");
    @(negedge clk);
    rst_a = 1'b0;
    idle("post_rst");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the core's fetch stage. It generates the instruction-memory address every cycle and selects between sequential step, taken branch, jump, register jump and call/return. It includes an optional hardware return-address stack (RAS) and a registered halt acknowledge. It supersedes the fixed 32-bit counter and feeds instruction memory directly from `pc_out`.

## Interface
- `WIDTH`, 32: address width in bits.
- `STEP`, 1: increment per sequential instruction (word-addressed memory uses 1).
- `RESET_VECTOR`, 0: value of `pc_out` after reset.
- `RAS_DEPTH`, 4: number of RAS entries (power of two, ≥2). Only used with `PC_RAS_EN`.
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Halt`  in  1  freeze the PC; no control input has effect while high.
- `Branch`  in  1  branch instruction in decode.
- `Zero`  in  1  ALU zero flag; the branch is taken when `Branch & Zero`.
- `Jump`  in  1  absolute jump to `AddressJump`.
- `JumpReg`  in  1  register jump to `AddressJump`.
- `Call`  in  1  jump to `AddressJump` and push the return address.
- `Return`  in  1  pop the return address from the RAS.
- `AddressJump`  in  WIDTH  target for branch, jump, jump-register and call.
- `pc_out`  out  WIDTH  current instruction address.
- `halted`  out  1  registered high while the PC is frozen.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- `ras_error`  out  1  sticky flag: RAS overflow or underflow occurred.

## Operation
- Priority on each rising edge, with `Halt`=0, highest first:
  1. Return: only with `PC_RAS_EN` and `ras_count`>0. The PC loads the top entry and `ras_count` decrements.
  2. `Branch & Zero`: PC loads `AddressJump`.
  3. `Jump`: PC loads `AddressJump`.
  4. `JumpReg`: PC loads `AddressJump`.
  5. `Call`: PC loads `AddressJump`. The RAS pushes `pc_out + STEP`.
  6. Otherwise: PC loads `pc_out + STEP`.
- Only the winning action has side effects. A `Call` that loses to a higher-priority input does not push.
- A `Return` that loses does not pop. `Return` never loses while the RAS is non-empty.
- `Return` with an empty RAS:
  - The PC steps by `STEP`.
  - `ras_error` sets.
  - `ras_count` stays 0.
- `Call` with a full RAS (`ras_count`==RAS_DEPTH):
  - The push overwrites the oldest entry (circular buffer).
  - `ras_count` stays RAS_DEPTH.
  - `ras_error` sets.
- Arithmetic: `pc_out + STEP` is computed modulo 2^WIDTH. All-ones plus 1 wraps to 0, with no flag.
- `Halt`=1: PC, RAS contents, `ras_count` and `ras_error` hold. All control inputs are ignored.
- Halt state machine, 2 states:
  - RUN goes to HALTED on an edge with `Halt`=1.
  - HALTED goes to RUN on an edge with `Halt`=0.
  - `halted` is high exactly in HALTED.
  - The first edge with `Halt`=0 already advances the PC.
- `ras_error` clears only on `Reset`.

## Timing
- Reset (asynchronous, immediate, regardless of clock):
  - `pc_out`=RESET_VECTOR.
  - `halted`=0.
  - `ras_count`=0.
  - `ras_error`=0.
  - RAS entries are don't-care.
- Deassertion of `Reset` is synchronised by the environment. The first edge after deassertion applies normal priority.
- All inputs are sampled on the rising edge. The chosen next PC appears on `pc_out` one cycle later, with no combinational input-to-output path.
- `ras_count`, `ras_error` and `halted` update on the same edge as the PC action that caused them.
- `Reset` asserted mid-operation aborts any push or pop in that cycle. The RAS is empty afterwards.

## Configuration
- `PC_RAS_EN` defined: the RAS is built as described above.
- `PC_RAS_EN` undefined:
  - No RAS storage is built.
  - `Call` acts as a plain jump to `AddressJump`.
  - `Return` is ignored: the lower priorities apply, which is a sequential step if nothing else is asserted.
  - `ras_count` and `ras_error` are tied to 0.
  - Ports and parameters are unchanged.

## Test plan
- Reset and step: assert `Reset` with RESET_VECTOR=0x100 and STEP=1, release, run 3 idle edges -> `pc_out` reads 0x100, 0x101, 0x102, 0x103. `halted`=0.
- Priority: at `pc_out`=0x10, drive `Branch`=1, `Zero`=1, `Jump`=1, `Call`=1, `AddressJump`=0x40 -> `pc_out`=0x40 and `ras_count` stays 0 (no push).
- Call/return (`PC_RAS_EN`): at 0x20, `Call` to 0x80, idle 2 edges, then `Return` -> `pc_out` sequence 0x80, 0x81, 0x82, 0x21. `ras_count` goes 1 then 0.
- RAS boundaries (RAS_DEPTH=4):
  - 5 nested calls -> `ras_count`=4 and `ras_error`=1. Then 4 returns yield the 2nd..5th return addresses in LIFO order.
  - A 5th return -> PC steps and `ras_count`=0.
- Halt and wrap: with WIDTH=8, `pc_out`=0xFF:
  - Hold `Halt` for 3 edges -> `pc_out` stays 0xFF and `halted`=1.
  - Release `Halt` -> next edge gives `pc_out`=0x00 and `halted`=0.
- Async reset mid-call: assert `Reset` between edges right after a `Call` -> `pc_out`=RESET_VECTOR immediately, `ras_count`=0 and `ras_error`=0.
